// File: rtl/maxpool_stream_if.sv
// Valid/ready stream bundle around the max-pool stage: the sample stream
// entering from the convolution block and the pooled stream leaving it.
interface maxpool_stream_if #(
  parameter int T = 16
);
  logic signed [T-1:0] x_data;
  logic                x_valid;
  logic                x_ready;
  logic signed [T-1:0] y_data;
  logic                y_valid;
  logic                y_ready;
  logic                y_last;

  // Surrounding logic: produces samples and consumes pooled results
  modport master (
    output x_data, x_valid, y_ready,
    input  x_ready, y_data, y_valid, y_last
  );

  // Pool stage: consumes samples and produces pooled results
  modport slave (
    input  x_data, x_valid, y_ready,
    output x_ready, y_data, y_valid, y_last
  );
endinterface

// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pool: signed max over non-overlapping windows of POOL
// samples, frame-aware (SIZE_IN samples per frame, short tail window emitted).
// A single output register (full flag = y_valid) sits between the window
// accumulator and the downstream consumer.
module maxpool_stream #(
  parameter int T       = 16,
  parameter int POOL    = 2,
  parameter int SIZE_IN = 16
) (
  input  logic            clk,
  input  logic            reset,
  maxpool_stream_if.slave pool_if
);

  localparam int WCW = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int ICW = (SIZE_IN > 1) ? $clog2(SIZE_IN) : 1;

  localparam logic [WCW-1:0] WIN_LAST = WCW'(POOL - 1);
  localparam logic [ICW-1:0] IN_LAST  = ICW'(SIZE_IN - 1);

  // Signed max; on a tie the running value is kept.
  function automatic logic signed [T-1:0] max_s(input logic signed [T-1:0] a,
                                                input logic signed [T-1:0] b);
    return (b > a) ? b : a;
  endfunction

  logic [WCW-1:0]      win_cnt;
  logic [ICW-1:0]      in_cnt;
  logic signed [T-1:0] acc;
  logic signed [T-1:0] y_data_p1;
  logic                y_last_p1;
  logic                vld_p1;

  logic                accept;
  logic                drain;
  logic                win_end;
  logic                frame_end;
  logic                closing_pos;
  logic                close;
  logic signed [T-1:0] win_max;

  // Handshake decode and the value the window would hold after this sample
  always_comb begin
    win_end     = (win_cnt == WIN_LAST);
    frame_end   = (in_cnt == IN_LAST);
    closing_pos = win_end || frame_end;
    // Only a window-closing sample needs the output register, so only it stalls.
    pool_if.x_ready = !(vld_p1 && !pool_if.y_ready && closing_pos);
    accept      = pool_if.x_valid && pool_if.x_ready;
    drain       = vld_p1 && pool_if.y_ready;
    close       = accept && closing_pos;
    win_max     = (win_cnt == '0) ? pool_if.x_data : max_s(acc, pool_if.x_data);
  end

  // Stage p0: window/frame position counters and running max
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
      in_cnt  <= '0;
      acc     <= '0;
    end else if (accept) begin
      acc     <= win_max;
      win_cnt <= closing_pos ? '0 : win_cnt + WCW'(1);
      in_cnt  <= frame_end ? '0 : in_cnt + ICW'(1);
    end
  end

  // Stage p1: output register; reload on close wins over drain (no bubble)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      y_data_p1 <= '0;
      y_last_p1 <= 1'b0;
    end else if (close) begin
      vld_p1    <= 1'b1;
      y_data_p1 <= win_max;
      y_last_p1 <= frame_end;
    end else if (drain) begin
      vld_p1    <= 1'b0;
    end
  end

  assign pool_if.y_valid = vld_p1;
  assign pool_if.y_data  = y_data_p1;
  assign pool_if.y_last  = y_last_p1;

endmodule

// File: tb/tb_maxpool_stream.sv
// Bench for maxpool_stream: four instances with different POOL/SIZE_IN,
// table-driven vectors plus hand-written backpressure and async-reset sequences.
module tb_maxpool_stream;

  logic clk;
  logic reset;

  logic signed [15:0] xd [4];
  logic               xv [4];
  logic               xr [4];
  logic signed [15:0] yd [4];
  logic               yv [4];
  logic               yr [4];
  logic               yl [4];

  int nchk;
  int nfail;

  maxpool_stream_if #(.T(16)) bus [4] ();

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      assign bus[g].x_data  = xd[g];
      assign bus[g].x_valid = xv[g];
      assign bus[g].y_ready = yr[g];
      assign xr[g] = bus[g].x_ready;
      assign yd[g] = bus[g].y_data;
      assign yv[g] = bus[g].y_valid;
      assign yl[g] = bus[g].y_last;

      maxpool_stream #(
        .T      (16),
        .POOL   ((g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 4 : 1),
        .SIZE_IN((g == 0) ? 6 : (g == 1) ? 7 : (g == 2) ? 8 : 4)
      ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .pool_if(bus[g])
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    int d;    // instance index
    int x;    // x_data applied
    bit v;    // x_valid applied
    bit r;    // y_ready applied
    bit exr;  // expected x_ready before the edge
    bit eyv;  // expected y_valid after the edge
    int ey;   // expected y_data after the edge (when y_valid)
    bit el;   // expected y_last after the edge (when y_valid)
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int d, int x, bit v, bit r, bit exr, bit eyv, int ey, bit el);
    vec_t t;
    t.d = d; t.x = x; t.v = v; t.r = r; t.exr = exr; t.eyv = eyv; t.ey = ey; t.el = el;
    tbl.push_back(t);
  endfunction

  task automatic chk(string nm, logic signed [31:0] act, logic signed [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(int d, int x, bit v, bit r);
    xd[d] = 16'(x);
    xv[d] = v;
    yr[d] = r;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(string nm, int d, bit eyv, int ey, bit el);
    chk({nm, " y_valid"}, yv[d], eyv);
    if (eyv) begin
      chk({nm, " y_data"}, yd[d], ey);
      chk({nm, " y_last"}, yl[d], el);
    end
  endtask

  int seq [6];

  initial begin
    nchk  = 0;
    nfail = 0;
    for (int i = 0; i < 4; i++) begin
      xd[i] = '0; xv[i] = 1'b0; yr[i] = 1'b1;
    end
    reset = 1'b1;

    // Vector table: test 1 (POOL=2, SIZE_IN=6)
    add(0,  3, 1, 1, 1, 0, 0, 0);
    add(0,  7, 1, 1, 1, 1, 7, 0);
    add(0, -2, 1, 1, 1, 0, 0, 0);
    add(0,  5, 1, 1, 1, 1, 5, 0);
    add(0,  9, 1, 1, 1, 0, 0, 0);
    add(0,  9, 1, 1, 1, 1, 9, 1);
    add(0,  0, 0, 1, 1, 0, 0, 0);
    // Test 2 (POOL=3, SIZE_IN=7): tail window of one, then a new frame
    for (int i = 1; i <= 7; i++)
      add(1, i, 1, 1, 1, (i == 3 || i == 6 || i == 7), i, (i == 7));
    add(1, 0, 1, 1, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 0, 0, 0);
    add(1, 0, 1, 1, 1, 1, 0, 0);
    add(1, 0, 0, 1, 1, 0, 0, 0);
    // Test 4 (POOL=4, SIZE_IN=8): negative values, then equal values
    add(2,     -8, 1, 1, 1, 0,  0, 0);
    add(2,     -3, 1, 1, 1, 0,  0, 0);
    add(2,     -5, 1, 1, 1, 0,  0, 0);
    add(2, -32768, 1, 1, 1, 1, -3, 0);
    add(2,      4, 1, 1, 1, 0,  0, 0);
    add(2,      4, 1, 1, 1, 0,  0, 0);
    add(2,      4, 1, 1, 1, 0,  0, 0);
    add(2,      4, 1, 1, 1, 1,  4, 1);
    add(2,      0, 0, 1, 1, 0,  0, 0);
    // Test 6 (POOL=1, SIZE_IN=4): registered pass-through over two frames
    for (int i = 0; i < 8; i++)
      add(3, 10 + i, 1, 1, 1, 1, 10 + i, (i == 3 || i == 7));
    add(3, 0, 0, 1, 1, 0, 0, 0);

    // Reset state of every instance
    #2;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset dut%0d y_valid", d), yv[d], 0);
      chk($sformatf("reset dut%0d y_data", d), yd[d], 0);
      chk($sformatf("reset dut%0d y_last", d), yl[d], 0);
      chk($sformatf("reset dut%0d x_ready", d), xr[d], 1);
    end
    #10;
    reset = 1'b0;
    cyc();

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].d, tbl[i].x, tbl[i].v, tbl[i].r);
      #1;
      chk($sformatf("vec%0d x_ready", i), xr[tbl[i].d], tbl[i].exr);
      cyc();
      chk_out($sformatf("vec%0d", i), tbl[i].d, tbl[i].eyv, tbl[i].ey, tbl[i].el);
    end

    // Test 3: backpressure on POOL=2, SIZE_IN=6
    drive(0, 1, 1, 1); cyc(); chk_out("bp s1", 0, 0, 0, 0);
    drive(0, 4, 1, 1); cyc(); chk_out("bp s4", 0, 1, 4, 0);
    drive(0, 6, 1, 0); #1;
    chk("bp open x_ready", xr[0], 1);
    cyc(); chk_out("bp hold1", 0, 1, 4, 0);
    drive(0, 8, 1, 0); #1;
    chk("bp stall1 x_ready", xr[0], 0);
    cyc(); chk_out("bp hold2", 0, 1, 4, 0);
    #1;
    chk("bp stall2 x_ready", xr[0], 0);
    cyc(); chk_out("bp hold3", 0, 1, 4, 0);
    drive(0, 8, 1, 1); #1;
    chk("bp release x_ready", xr[0], 1);
    cyc(); chk_out("bp reload", 0, 1, 8, 0);
    drive(0, 2, 1, 1); cyc(); chk_out("bp drain", 0, 0, 0, 0);
    drive(0, -1, 1, 1); cyc(); chk_out("bp tail", 0, 1, 2, 1);
    drive(0, 0, 0, 1); cyc(); chk_out("bp idle", 0, 0, 0, 0);

    // Test 5: async reset mid-window
    drive(0, 5, 1, 1); cyc(); chk_out("ar half", 0, 0, 0, 0);
    drive(0, 0, 0, 1);
    #2 reset = 1'b1;
    #1 chk("ar1 y_valid", yv[0], 0);
    #1 reset = 1'b0;
    cyc();
    drive(0, 3, 1, 1); cyc(); chk_out("ar fresh1", 0, 0, 0, 0);
    drive(0, 9, 1, 1); cyc(); chk_out("ar fresh2", 0, 1, 9, 0);
    // Async reset while the output register is stalled
    drive(0, 0, 0, 0); cyc(); chk_out("ar stalled", 0, 1, 9, 0);
    #2 reset = 1'b1;
    #1;
    chk("ar2 y_valid", yv[0], 0);
    chk("ar2 y_data", yd[0], 0);
    chk("ar2 x_ready", xr[0], 1);
    #1 reset = 1'b0;
    cyc();
    seq = '{20, -4, 1, 2, 3, 4};
    for (int i = 0; i < 6; i++) begin
      drive(0, seq[i], 1, 1);
      cyc();
      if (i % 2 == 1)
        chk_out($sformatf("ar frame s%0d", i), 0, 1,
                (seq[i - 1] > seq[i]) ? seq[i - 1] : seq[i], (i == 5));
      else
        chk_out($sformatf("ar frame s%0d", i), 0, 0, 0, 0);
    end
    drive(0, 0, 0, 1); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
